// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake and control bundle between the multicycle control FSM and its
// environment: instruction fields and memory-ready in, datapath controls out.
interface multicycle_ctrl_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic [1:0] flag_w;
  logic [3:0] state;

  modport master (
    output op, funct, mem_ready,
    input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, flag_w, state
  );

  modport slave (
    input  op, funct, mem_ready,
    output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, flag_w, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle datapath: sequences fetch, decode,
// execute, memory and writeback, and stalls on the memory-ready handshake.
module multicycle_ctrl_fsm (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic       w_ir_write;
  logic       w_next_pc;
  logic       w_adr_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic       w_alu_op;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_branch;
  logic [1:0] w_flag_w;

  // TST/TEQ/CMP/CMN (cmd 10xx) only update flags and skip register writeback.
  function automatic logic is_test_cmd(input logic [3:0] cmd);
    return (cmd[3:2] == 2'b10);
  endfunction

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.op)
          2'b00: begin
            if (bus.funct[5]) begin
              w_next_state = S_EXECI;
            end else begin
              w_next_state = S_EXECR;
            end
          end
          2'b01:   w_next_state = S_MEMADR;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_EXECR, S_EXECI: begin
        if (is_test_cmd(bus.funct[4:1])) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_ALUWB;
        end
      end
      S_ALUWB: w_next_state = S_FETCH;
      S_MEMADR: begin
        if (bus.funct[0]) begin
          w_next_state = S_MEMRD;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (bus.mem_ready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMWB: w_next_state = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_BRANCH: w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Output decode; reset overrides the state so enables drop the same cycle.
  always_comb begin
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_alu_op     = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_flag_w     = 2'b00;
    if (rst) begin
      w_alu_src_a  = 1'b1;
      w_alu_src_b  = 2'b10;
      w_result_src = 2'b10;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_alu_src_a  = 1'b1;
          w_alu_src_b  = 2'b10;
          w_result_src = 2'b10;
          w_ir_write   = bus.mem_ready;
          w_next_pc    = bus.mem_ready;
        end
        S_DECODE: begin
          w_alu_src_a  = 1'b1;
          w_alu_src_b  = 2'b10;
          w_result_src = 2'b10;
        end
        S_EXECR: begin
          w_alu_op = 1'b1;
          w_flag_w = bus.funct[0] ? 2'b11 : 2'b00;
        end
        S_EXECI: begin
          w_alu_src_b = 2'b01;
          w_alu_op    = 1'b1;
          w_flag_w    = bus.funct[0] ? 2'b11 : 2'b00;
        end
        S_ALUWB: begin
          w_result_src = 2'b00;
          w_reg_w      = 1'b1;
        end
        S_MEMADR: begin
          w_alu_src_b = 2'b01;
        end
        S_MEMRD: begin
          w_adr_src = 1'b1;
        end
        S_MEMWB: begin
          w_result_src = 2'b01;
          w_reg_w      = 1'b1;
        end
        S_MEMWR: begin
          w_adr_src = 1'b1;
          w_mem_w   = 1'b1;
        end
        S_BRANCH: begin
          w_alu_src_b  = 2'b01;
          w_result_src = 2'b10;
          w_branch     = 1'b1;
        end
        default: begin
          w_ir_write = 1'b0;
        end
      endcase
    end
  end

  assign bus.ir_write   = w_ir_write;
  assign bus.next_pc    = w_next_pc;
  assign bus.adr_src    = w_adr_src;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.result_src = w_result_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.reg_w      = w_reg_w;
  assign bus.mem_w      = w_mem_w;
  assign bus.branch     = w_branch;
  assign bus.flag_w     = w_flag_w;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus pushes the hand-computed
// per-cycle state and control word; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;
  logic clk;
  logic rst;

  multicycle_ctrl_fsm_if bus_if ();

  multicycle_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: ir_write,next_pc,adr_src,alu_src_a,alu_src_b,result_src,
  //               alu_op,reg_w,mem_w,branch,flag_w
  localparam logic [13:0] O_FETCH0 = 14'b0001_10_10_0000_00;
  localparam logic [13:0] O_FETCH1 = 14'b1101_10_10_0000_00;
  localparam logic [13:0] O_DECODE = 14'b0001_10_10_0000_00;
  localparam logic [13:0] O_EXECR0 = 14'b0000_00_00_1000_00;
  localparam logic [13:0] O_EXECR1 = 14'b0000_00_00_1000_11;
  localparam logic [13:0] O_EXECI0 = 14'b0000_01_00_1000_00;
  localparam logic [13:0] O_EXECI1 = 14'b0000_01_00_1000_11;
  localparam logic [13:0] O_ALUWB  = 14'b0000_00_00_0100_00;
  localparam logic [13:0] O_MEMADR = 14'b0000_01_00_0000_00;
  localparam logic [13:0] O_MEMRD  = 14'b0010_00_00_0000_00;
  localparam logic [13:0] O_MEMWB  = 14'b0000_00_01_0100_00;
  localparam logic [13:0] O_MEMWR  = 14'b0010_00_00_0010_00;
  localparam logic [13:0] O_BRANCH = 14'b0000_01_10_0001_00;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Monitor: compare the DUT's state and control word mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_item_t it;
      logic [17:0] act;
      it  = sb_q.pop_front();
      act = {bus_if.state, bus_if.ir_write, bus_if.next_pc, bus_if.adr_src,
             bus_if.alu_src_a, bus_if.alu_src_b, bus_if.result_src,
             bus_if.alu_op, bus_if.reg_w, bus_if.mem_w, bus_if.branch,
             bus_if.flag_w};
      n_checks++;
      if (act !== it.exp) begin
        n_errors++;
        $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 it.name, act[17:14], act[13:0], it.exp[17:14], it.exp[13:0]);
      end
    end
  end

  task automatic cyc(input string name, input logic r, input logic [1:0] o,
                     input logic [5:0] f, input logic mr,
                     input logic [3:0] st, input logic [13:0] outs);
    sb_item_t it;
    rst              = r;
    bus_if.op        = o;
    bus_if.funct     = f;
    bus_if.mem_ready = mr;
    it.name = name;
    it.exp  = {st, outs};
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    bus_if.op        = 2'b00;
    bus_if.funct     = 6'b000000;
    bus_if.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset: held two cycles, mem_ready ignored while in reset
    cyc("rst_hold",    1'b1, 2'b00, 6'b000000, 1'b0, 4'd0, O_FETCH0);
    cyc("rst_hold_mr", 1'b1, 2'b00, 6'b000000, 1'b1, 4'd0, O_FETCH0);
    cyc("fetch_wait0", 1'b0, 2'b00, 6'b000000, 1'b0, 4'd0, O_FETCH0);
    cyc("fetch_wait1", 1'b0, 2'b00, 6'b000000, 1'b0, 4'd0, O_FETCH0);

    // ADD register, S=0
    cyc("add_fetch",  1'b0, 2'b00, 6'b001000, 1'b1, 4'd0, O_FETCH1);
    cyc("add_decode", 1'b0, 2'b00, 6'b001000, 1'b1, 4'd1, O_DECODE);
    cyc("add_execr",  1'b0, 2'b00, 6'b001000, 1'b1, 4'd6, O_EXECR0);
    cyc("add_aluwb",  1'b0, 2'b00, 6'b001000, 1'b1, 4'd8, O_ALUWB);

    // CMP immediate, S=1
    cyc("cmp_fetch",  1'b0, 2'b00, 6'b110101, 1'b1, 4'd0, O_FETCH1);
    cyc("cmp_decode", 1'b0, 2'b00, 6'b110101, 1'b1, 4'd1, O_DECODE);
    cyc("cmp_execi",  1'b0, 2'b00, 6'b110101, 1'b1, 4'd7, O_EXECI1);

    // ORR register, S=1: flags and writeback
    cyc("orr_fetch",  1'b0, 2'b00, 6'b011001, 1'b1, 4'd0, O_FETCH1);
    cyc("orr_decode", 1'b0, 2'b00, 6'b011001, 1'b1, 4'd1, O_DECODE);
    cyc("orr_execr",  1'b0, 2'b00, 6'b011001, 1'b1, 4'd6, O_EXECR1);
    cyc("orr_aluwb",  1'b0, 2'b00, 6'b011001, 1'b1, 4'd8, O_ALUWB);

    // TST register: no writeback
    cyc("tst_fetch",  1'b0, 2'b00, 6'b010001, 1'b1, 4'd0, O_FETCH1);
    cyc("tst_decode", 1'b0, 2'b00, 6'b010001, 1'b1, 4'd1, O_DECODE);
    cyc("tst_execr",  1'b0, 2'b00, 6'b010001, 1'b1, 4'd6, O_EXECR1);

    // ADD immediate, S=0
    cyc("addi_fetch",  1'b0, 2'b00, 6'b101000, 1'b1, 4'd0, O_FETCH1);
    cyc("addi_decode", 1'b0, 2'b00, 6'b101000, 1'b1, 4'd1, O_DECODE);
    cyc("addi_execi",  1'b0, 2'b00, 6'b101000, 1'b1, 4'd7, O_EXECI0);
    cyc("addi_aluwb",  1'b0, 2'b00, 6'b101000, 1'b1, 4'd8, O_ALUWB);

    // LDR with two wait cycles in MEMRD
    cyc("ldr_fetch",  1'b0, 2'b01, 6'b011001, 1'b1, 4'd0, O_FETCH1);
    cyc("ldr_decode", 1'b0, 2'b01, 6'b011001, 1'b1, 4'd1, O_DECODE);
    cyc("ldr_memadr", 1'b0, 2'b01, 6'b011001, 1'b1, 4'd2, O_MEMADR);
    cyc("ldr_memrd0", 1'b0, 2'b01, 6'b011001, 1'b0, 4'd3, O_MEMRD);
    cyc("ldr_memrd1", 1'b0, 2'b01, 6'b011001, 1'b0, 4'd3, O_MEMRD);
    cyc("ldr_memrd2", 1'b0, 2'b01, 6'b011001, 1'b1, 4'd3, O_MEMRD);
    cyc("ldr_memwb",  1'b0, 2'b01, 6'b011001, 1'b1, 4'd4, O_MEMWB);

    // STR with one wait cycle in MEMWR
    cyc("str_fetch",  1'b0, 2'b01, 6'b011000, 1'b1, 4'd0, O_FETCH1);
    cyc("str_decode", 1'b0, 2'b01, 6'b011000, 1'b1, 4'd1, O_DECODE);
    cyc("str_memadr", 1'b0, 2'b01, 6'b011000, 1'b1, 4'd2, O_MEMADR);
    cyc("str_memwr0", 1'b0, 2'b01, 6'b011000, 1'b0, 4'd5, O_MEMWR);
    cyc("str_memwr1", 1'b0, 2'b01, 6'b011000, 1'b1, 4'd5, O_MEMWR);

    // Branch
    cyc("b_fetch",  1'b0, 2'b10, 6'b000000, 1'b1, 4'd0, O_FETCH1);
    cyc("b_decode", 1'b0, 2'b10, 6'b000000, 1'b1, 4'd1, O_DECODE);
    cyc("b_branch", 1'b0, 2'b10, 6'b000000, 1'b1, 4'd9, O_BRANCH);

    // Reset asserted while stalled in MEMWR
    cyc("rstwr_fetch",  1'b0, 2'b01, 6'b011000, 1'b1, 4'd0, O_FETCH1);
    cyc("rstwr_decode", 1'b0, 2'b01, 6'b011000, 1'b1, 4'd1, O_DECODE);
    cyc("rstwr_memadr", 1'b0, 2'b01, 6'b011000, 1'b1, 4'd2, O_MEMADR);
    cyc("rstwr_memwr",  1'b0, 2'b01, 6'b011000, 1'b0, 4'd5, O_MEMWR);
    cyc("rstwr_abort",  1'b1, 2'b01, 6'b011000, 1'b0, 4'd5, O_FETCH0);
    cyc("rstwr_after",  1'b0, 2'b01, 6'b011000, 1'b0, 4'd0, O_FETCH0);

    // op=11 no-op
    cyc("nop_fetch",  1'b0, 2'b11, 6'b111111, 1'b1, 4'd0, O_FETCH1);
    cyc("nop_decode", 1'b0, 2'b11, 6'b111111, 1'b1, 4'd1, O_DECODE);
    cyc("nop_back",   1'b0, 2'b11, 6'b111111, 1'b0, 4'd0, O_FETCH0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
